// File: rtl/daynight_ctrl.sv
// Scene timebase: detects frame starts on vsync, counts frames and sweeps a
// wrapping 8-bit day/night phase with dwell periods at midnight and midday.
module daynight_ctrl #(
  parameter int HOLD_FRAMES = 120,
  parameter int DAY_LVL     = 136
) (
  input  logic        clk_pix,
  input  logic        rst_n,
  input  logic        vsync,
  input  logic [3:0]  step_div,
  input  logic        pause,
  input  logic        jump,
  output logic [15:0] frame_count,
  output logic [7:0]  fade_level,
  output logic        night,
  output logic [1:0]  phase_state,
  output logic        cycle_done
);

  typedef enum logic [1:0] {
    ADV    = 2'd0,
    HOLD_N = 2'd1,
    HOLD_D = 2'd2
  } phase_t;

  localparam int              HC_W      = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_FRAMES - 1);
  localparam logic [7:0]      DAY_L     = 8'(DAY_LVL);

  phase_t          state_q, state_d;
  logic [HC_W-1:0] hold_q, hold_d;
  logic [3:0]      div_q, div_d;
  logic [7:0]      fade_d;
  logic [15:0]     frame_d;
  logic            cd_d;
  logic            vs_q;
  logic            tick;
  logic [4:0]      eff_div;
  logic [4:0]      div_inc;
  logic [7:0]      fade_inc;

  // Same thresholds the stars stage applies to fade_level.
  function automatic logic is_night(input logic [7:0] f);
    return (f < 8'd64) || (f > 8'd208);
  endfunction

  assign tick     = vsync & ~vs_q;
  assign eff_div  = (step_div == 4'd0) ? 5'd1 : {1'b0, step_div};
  assign div_inc  = {1'b0, div_q} + 5'd1;
  assign fade_inc = fade_level + 8'd1;

  always_ff @(posedge clk_pix) begin
    if (!rst_n) begin
      state_q     <= HOLD_N;
      hold_q      <= '0;
      div_q       <= '0;
      fade_level  <= '0;
      frame_count <= '0;
      cycle_done  <= 1'b0;
      night       <= 1'b1;
      vs_q        <= 1'b1;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      div_q       <= div_d;
      fade_level  <= fade_d;
      frame_count <= frame_d;
      cycle_done  <= cd_d;
      night       <= is_night(fade_d);
      vs_q        <= vsync;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    div_d   = div_q;
    fade_d  = fade_level;
    cd_d    = 1'b0;
    frame_d = frame_count + {15'd0, tick};

    // A jump overrides any tick effect on the phase; a jump-induced wrap is not a cycle_done.
    if (jump) begin
      if (state_q == HOLD_D || fade_level >= DAY_L) begin
        fade_d  = 8'd0;
        state_d = HOLD_N;
      end else begin
        fade_d  = DAY_L;
        state_d = HOLD_D;
      end
      hold_d = '0;
      div_d  = '0;
    end else if (tick && !pause) begin
      unique case (state_q)
        ADV: begin
          if (div_inc >= eff_div) begin
            div_d  = '0;
            fade_d = fade_inc;
            if (fade_inc == 8'd0) begin
              state_d = HOLD_N;
              cd_d    = 1'b1;
              hold_d  = '0;
            end else if (fade_inc == DAY_L) begin
              state_d = HOLD_D;
              hold_d  = '0;
            end
          end else begin
            div_d = div_inc[3:0];
          end
        end
        HOLD_N, HOLD_D: begin
          if (hold_q == HOLD_LAST) begin
            state_d = ADV;
            hold_d  = '0;
            div_d   = '0;
          end else begin
            hold_d = hold_q + HC_W'(1);
          end
        end
        default: state_d = HOLD_N;
      endcase
    end
  end

  assign phase_state = state_q;

endmodule

// File: tb/tb_daynight_ctrl.sv
// Randomized and directed bench for daynight_ctrl against a frame-level
// reference model of the phase sweep, holds, pause and jump rules.
module tb_daynight_ctrl;

  localparam int HF  = 4;
  localparam int DAY = 136;

  logic        clk_pix = 1'b0;
  logic        rst_n;
  logic        vsync;
  logic [3:0]  step_div;
  logic        pause;
  logic        jump;
  logic [15:0] frame_count;
  logic [7:0]  fade_level;
  logic        night;
  logic [1:0]  phase_state;
  logic        cycle_done;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  int m_fc, m_fade, m_phase, m_hold, m_div;
  bit m_cd, m_vsq;

  daynight_ctrl #(.HOLD_FRAMES(HF), .DAY_LVL(DAY)) dut (
    .clk_pix(clk_pix), .rst_n(rst_n), .vsync(vsync), .step_div(step_div),
    .pause(pause), .jump(jump), .frame_count(frame_count), .fade_level(fade_level),
    .night(night), .phase_state(phase_state), .cycle_done(cycle_done)
  );

  always #5 clk_pix = ~clk_pix;

  task automatic model_step();
    int  ed;
    bit  tk;
    if (!rst_n) begin
      m_fc = 0; m_fade = 0; m_phase = 1; m_cd = 0; m_hold = 0; m_div = 0; m_vsq = 1;
      return;
    end
    tk    = vsync && !m_vsq;
    m_vsq = vsync;
    m_cd  = 0;
    if (tk) m_fc = (m_fc + 1) % 65536;
    ed = (step_div == 0) ? 1 : int'(step_div);
    if (jump) begin
      if (m_phase == 2 || m_fade >= DAY) begin m_fade = 0; m_phase = 1; end
      else begin m_fade = DAY; m_phase = 2; end
      m_hold = 0; m_div = 0;
    end else if (tk && !pause) begin
      if (m_phase == 0) begin
        if (m_div + 1 >= ed) begin
          m_div  = 0;
          m_fade = (m_fade + 1) % 256;
          if (m_fade == 0) begin m_phase = 1; m_cd = 1; m_hold = 0; end
          else if (m_fade == DAY) begin m_phase = 2; m_hold = 0; end
        end else m_div++;
      end else if (m_hold == HF - 1) begin
        m_phase = 0; m_hold = 0; m_div = 0;
      end else m_hold++;
    end
  endtask

  // One clock; outputs are stable 1 ns after the edge.
  task automatic cyc();
    @(posedge clk_pix);
    #1;
    model_step();
  endtask

  task automatic do_tick();
    vsync = 1'b0; cyc();
    vsync = 1'b1; cyc();
  endtask

  task automatic run_to(input int target, output bit ok);
    int guard = 0;
    while (m_fade != target && guard < 1200) begin
      do_tick();
      guard++;
    end
    ok = (m_fade == target);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; vsync = 1'b1; step_div = 4'd1; pause = 1'b0; jump = 1'b0;
    repeat (3) cyc();
    rst_n = 1'b1;
    repeat (3) cyc();
    n_checks++;
    if (frame_count !== 16'd0) begin n_errors++; $display("FAIL reset_fc: got %0d want 0", frame_count); end
    n_checks++;
    if (fade_level !== 8'd0) begin n_errors++; $display("FAIL reset_fade: got %0d want 0", fade_level); end
    n_checks++;
    if (phase_state !== 2'd1 || night !== 1'b1 || cycle_done !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_ctrl: got phase=%0d night=%0b cd=%0b want 1/1/0", phase_state, night, cycle_done);
    end
  endtask

  task automatic test_hold_release();
    for (int i = 1; i <= 3; i++) begin
      do_tick();
      n_checks++;
      if (phase_state !== 2'd1) begin n_errors++; $display("FAIL hold_n_tick%0d: got phase %0d want 1", i, phase_state); end
    end
    do_tick();
    n_checks++;
    if (phase_state !== 2'd0 || fade_level !== 8'd0) begin
      n_errors++; $display("FAIL hold_n_exit: got phase=%0d fade=%0d want 0/0", phase_state, fade_level);
    end
    do_tick();
    n_checks++;
    if (fade_level !== 8'd1 || frame_count !== 16'd5) begin
      n_errors++; $display("FAIL first_step: got fade=%0d fc=%0d want 1/5", fade_level, frame_count);
    end
  endtask

  task automatic test_step_div();
    bit ok;
    run_to(10, ok);
    n_checks++;
    if (!ok || fade_level !== 8'd10) begin n_errors++; $display("FAIL reach_10: got fade %0d want 10", fade_level); end
    step_div = 4'd3;
    do_tick(); do_tick();
    n_checks++;
    if (fade_level !== 8'd10) begin n_errors++; $display("FAIL div3_hold: got %0d want 10", fade_level); end
    do_tick();
    n_checks++;
    if (fade_level !== 8'd11) begin n_errors++; $display("FAIL div3_first: got %0d want 11", fade_level); end
    repeat (3) do_tick();
    n_checks++;
    if (fade_level !== 8'd12) begin n_errors++; $display("FAIL div3_second: got %0d want 12", fade_level); end
    step_div = 4'd0;
    do_tick();
    n_checks++;
    if (fade_level !== 8'd13) begin n_errors++; $display("FAIL div0: got %0d want 13", fade_level); end
    step_div = 4'd1;
  endtask

  task automatic test_night_and_day();
    bit ok;
    run_to(63, ok);
    n_checks++;
    if (!ok || night !== 1'b1) begin n_errors++; $display("FAIL night_63: got %0b want 1", night); end
    do_tick();
    n_checks++;
    if (fade_level !== 8'd64 || night !== 1'b0) begin
      n_errors++; $display("FAIL night_64: got fade=%0d night=%0b want 64/0", fade_level, night);
    end
    run_to(DAY, ok);
    n_checks++;
    if (!ok || phase_state !== 2'd2 || fade_level !== 8'(DAY)) begin
      n_errors++; $display("FAIL day_hold: got phase=%0d fade=%0d want 2/136", phase_state, fade_level);
    end
    n_checks++;
    if (frame_count !== 16'(m_fc)) begin n_errors++; $display("FAIL day_fc: got %0d want %0d", frame_count, m_fc); end
    repeat (3) do_tick();
    n_checks++;
    if (phase_state !== 2'd2) begin n_errors++; $display("FAIL day_dwell: got phase %0d want 2", phase_state); end
    do_tick();
    n_checks++;
    if (phase_state !== 2'd0 || fade_level !== 8'(DAY)) begin
      n_errors++; $display("FAIL day_exit: got phase=%0d fade=%0d want 0/136", phase_state, fade_level);
    end
    run_to(208, ok);
    n_checks++;
    if (!ok || night !== 1'b0) begin n_errors++; $display("FAIL night_208: got %0b want 0", night); end
    do_tick();
    n_checks++;
    if (fade_level !== 8'd209 || night !== 1'b1) begin
      n_errors++; $display("FAIL night_209: got fade=%0d night=%0b want 209/1", fade_level, night);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    run_to(255, ok);
    n_checks++;
    if (!ok || fade_level !== 8'd255 || cycle_done !== 1'b0) begin
      n_errors++; $display("FAIL pre_wrap: got fade=%0d cd=%0b want 255/0", fade_level, cycle_done);
    end
    do_tick();
    n_checks++;
    if (fade_level !== 8'd0 || cycle_done !== 1'b1 || phase_state !== 2'd1) begin
      n_errors++;
      $display("FAIL wrap: got fade=%0d cd=%0b phase=%0d want 0/1/1", fade_level, cycle_done, phase_state);
    end
    cyc();
    n_checks++;
    if (cycle_done !== 1'b0) begin n_errors++; $display("FAIL wrap_pulse: got cd %0b want 0", cycle_done); end
  endtask

  task automatic test_pause_jump();
    bit ok;
    int fc0;
    run_to(50, ok);
    fc0   = m_fc;
    pause = 1'b1;
    repeat (10) do_tick();
    n_checks++;
    if (!ok || fade_level !== 8'd50) begin n_errors++; $display("FAIL pause_fade: got %0d want 50", fade_level); end
    n_checks++;
    if (frame_count !== 16'(fc0 + 10)) begin
      n_errors++; $display("FAIL pause_fc: got %0d want %0d", frame_count, fc0 + 10);
    end
    jump = 1'b1; cyc(); jump = 1'b0;
    n_checks++;
    if (fade_level !== 8'(DAY) || phase_state !== 2'd2) begin
      n_errors++; $display("FAIL jump_day: got fade=%0d phase=%0d want 136/2", fade_level, phase_state);
    end
    jump = 1'b1; cyc(); jump = 1'b0;
    n_checks++;
    if (fade_level !== 8'd0 || phase_state !== 2'd1 || cycle_done !== 1'b0) begin
      n_errors++;
      $display("FAIL jump_night: got fade=%0d phase=%0d cd=%0b want 0/1/0", fade_level, phase_state, cycle_done);
    end
    pause = 1'b0;
  endtask

  task automatic test_reset_mid_hold();
    jump = 1'b1; cyc(); jump = 1'b0;
    do_tick();
    n_checks++;
    if (phase_state !== 2'd2) begin n_errors++; $display("FAIL pre_rst_hold: got phase %0d want 2", phase_state); end
    rst_n = 1'b0; cyc(); rst_n = 1'b1;
    n_checks++;
    if (fade_level !== 8'd0 || phase_state !== 2'd1 || night !== 1'b1 || frame_count !== 16'd0 || cycle_done !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_mid_hold: got fade=%0d phase=%0d night=%0b fc=%0d cd=%0b want 0/1/1/0/0",
               fade_level, phase_state, night, frame_count, cycle_done);
    end
  endtask

  task automatic test_random();
    bit exp_night;
    for (int i = 0; i < 6000; i++) begin
      vsync = ($urandom_range(0, 2) != 0);
      pause = ($urandom_range(0, 9) == 0);
      jump  = ($urandom_range(0, 63) == 0);
      rst_n = ($urandom_range(0, 499) != 0);
      if ($urandom_range(0, 49) == 0) step_div = 4'($urandom_range(0, 15));
      cyc();
      exp_night = (m_fade < 64) || (m_fade > 208);
      n_checks++;
      if (frame_count !== 16'(m_fc) || fade_level !== 8'(m_fade) || phase_state !== 2'(m_phase) ||
          cycle_done !== m_cd || night !== exp_night) begin
        n_errors++;
        $display("FAIL random_c%0d: got fc=%0d fade=%0d ph=%0d cd=%0b n=%0b want %0d/%0d/%0d/%0b/%0b",
                 i, frame_count, fade_level, phase_state, cycle_done, night,
                 m_fc, m_fade, m_phase, m_cd, exp_night);
      end
    end
    rst_n = 1'b1; pause = 1'b0; jump = 1'b0;
  endtask

  initial begin
    test_reset();
    test_hold_release();
    test_step_div();
    test_night_and_day();
    test_wrap();
    test_pause_jump();
    test_reset_mid_hold();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
